adc_capture_ctrl: RTL and testbench



---
 rtl/adc_capture_pkg.sv | 20 ++
 rtl/adc_sample_fifo.sv | 50 +++++
 rtl/adc_capture_ctrl.sv | 150 +++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared types and default widths for the ADC capture sequencer
// Holds the controller state enum, the trigger-mode enum and the default parameter values.
package adc_capture_pkg;
  localparam int unsigned DW_DEF         = 12;
  localparam int unsigned LEN_W_DEF      = 16;
  localparam int unsigned DEC_W_DEF      = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 8;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_e;
  typedef enum logic [1:0] {
    TRIG_IMM    = 2'd0,
    TRIG_THRESH = 2'd1,
    TRIG_EXT    = 2'd2,
    TRIG_RSVD   = 2'd3
  } trig_mode_e;
endpackage

// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo: synchronous first-word-fall-through FIFO with flush
// Ports: clk/rst_n clock and async active-low reset; flush_i empties the FIFO;
//   wr_i/wdata_i write side; rd_i read strobe (pops the head when valid_o);
//   rdata_o head entry (zero when empty); valid_o not empty; full_o no free slot.
module adc_sample_fifo
  import adc_capture_pkg::*;
#(
  parameter int unsigned W     = 25,
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         wr_i,
  input  logic [W-1:0] wdata_i,
  input  logic         rd_i,
  output logic [W-1:0] rdata_o,
  output logic         valid_o,
  output logic         full_o
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          do_wr, do_rd;
  assign valid_o = cnt_q != '0;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign do_rd   = rd_i && valid_o;
  // a pop in the same cycle frees the slot, so a write into a full FIFO still lands
  assign do_wr   = wr_i && (!full_o || do_rd);
  assign rdata_o = valid_o ? mem_q[rp_q] : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= do_wr ? wp_q + 1'b1 : wp_q;
      rp_q  <= do_rd ? rp_q + 1'b1 : rp_q;
      cnt_q <= cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wp_q] <= wdata_i;
  end
endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: dual-channel ADC capture sequencer (arm, trigger, decimate, collect, drain)
// Ports: sys_clk/rst_n clock and async active-low reset; ad_data_ch0/ch1 raw samples;
//   cfg_start/cfg_abort command pulses; cfg_len/cfg_decim/cfg_trig_mode/cfg_thresh
//   configuration latched on an accepted start; ext_trig external trigger level;
//   m_valid/m_ready/m_data/m_last output stream ({ch1, ch0}); busy/done/overflow/sample_cnt status.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned LEN_W      = LEN_W_DEF,
  parameter int unsigned DEC_W      = DEC_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     ad_data_ch0,
  input  logic [DW-1:0]     ad_data_ch1,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [DEC_W-1:0]  cfg_decim,
  input  logic [1:0]        cfg_trig_mode,
  input  logic [DW-1:0]     cfg_thresh,
  input  logic              ext_trig,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [2*DW-1:0]   m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [LEN_W-1:0]  sample_cnt
);
  localparam int unsigned FW = 2 * DW + 1;
  state_e           state_q, state_d;
  trig_mode_e       mode_q, mode_d;
  logic [DW-1:0]    ch0_q, ch1_q, prev_q, thresh_q, thresh_d;
  logic             prev_vld_q;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [DEC_W-1:0] decim_q, decim_d, dec_q, dec_d;
  logic             ovf_q, ovf_d, done_q, done_d;
  logic             trig, keep, last_wr, fifo_full, fifo_room, wr;
  logic [FW-1:0]    rdata;
  // threshold mode needs a valid previous sample, which is only true from the second ARMED cycle
  assign trig = (mode_q == TRIG_THRESH) ? (prev_vld_q && prev_q < thresh_q && ch0_q >= thresh_q) :
                (mode_q == TRIG_EXT)    ? ext_trig : 1'b1;
  assign keep      = dec_q == '0;
  assign last_wr   = cnt_q + 1'b1 == len_q;
  assign fifo_room = !fifo_full || m_ready;
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    len_d    = len_q;
    decim_d  = decim_q;
    thresh_d = thresh_q;
    dec_d    = dec_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    wr       = 1'b0;
    if (cfg_abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_start && cfg_len != '0) begin
            state_d  = ARMED;
            mode_d   = trig_mode_e'(cfg_trig_mode);
            len_d    = cfg_len;
            decim_d  = cfg_decim;
            thresh_d = cfg_thresh;
            cnt_d    = '0;
            ovf_d    = 1'b0;
          end
        end
        ARMED: begin
          if (trig) begin
            state_d = CAPTURE;
            dec_d   = '0;
          end
        end
        CAPTURE: begin
          dec_d = keep ? decim_q : dec_q - 1'b1;
          if (keep && fifo_room) begin
            wr      = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            state_d = last_wr ? DRAIN : CAPTURE;
          end
          ovf_d = ovf_q || (keep && !fifo_room);
        end
        DRAIN: begin
          if (m_valid && m_ready && m_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      endcase
    end
  end
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= TRIG_IMM;
      len_q      <= '0;
      decim_q    <= '0;
      thresh_q   <= '0;
      dec_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      ch0_q      <= '0;
      ch1_q      <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      decim_q    <= decim_d;
      thresh_q   <= thresh_d;
      dec_q      <= dec_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      ch0_q      <= ad_data_ch0;
      ch1_q      <= ad_data_ch1;
      prev_q     <= ch0_q;
      prev_vld_q <= state_q == ARMED;
    end
  end
  adc_sample_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .rst_n   (rst_n),
    .flush_i (cfg_abort),
    .wr_i    (wr),
    .wdata_i ({last_wr, ch1_q, ch0_q}),
    .rd_i    (m_ready),
    .rdata_o (rdata),
    .valid_o (m_valid),
    .full_o  (fifo_full)
  );
  assign {m_last, m_data} = rdata;
  assign busy       = state_q != IDLE;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign sample_cnt = cnt_q;
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: directed self-checking bench for adc_capture_ctrl
module tb_adc_capture_ctrl;
  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] ad_data_ch0 = '0, ad_data_ch1 = '0;
  logic        cfg_start = 1'b0, cfg_abort = 1'b0;
  logic [15:0] cfg_len = '0;
  logic [7:0]  cfg_decim = '0;
  logic [1:0]  cfg_trig_mode = '0;
  logic [11:0] cfg_thresh = '0;
  logic        ext_trig = 1'b0;
  logic        m_valid, m_ready = 1'b0, m_last, busy, done, overflow;
  logic [23:0] m_data;
  logic [15:0] sample_cnt;
  adc_capture_ctrl dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .ad_data_ch0(ad_data_ch0), .ad_data_ch1(ad_data_ch1),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_len(cfg_len), .cfg_decim(cfg_decim),
    .cfg_trig_mode(cfg_trig_mode), .cfg_thresh(cfg_thresh), .ext_trig(ext_trig),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy),
    .done(done), .overflow(overflow), .sample_cnt(sample_cnt)
  );
  always #5 sys_clk = ~sys_clk;
  int checks = 0, errors = 0;
  int n = 0, done_cnt = 0, done_n = -1;
  bit ramp = 1'b0;
  logic busy_at_done = 1'b0;
  logic [23:0] bd[$];
  logic bl[$];
  int bn[$];
  function automatic logic [23:0] beat(input int v);
    return {12'h800 + 12'(v), 12'(v)};
  endfunction
  task automatic cycle();
    if (m_valid && m_ready) begin
      bd.push_back(m_data);
      bl.push_back(m_last);
      bn.push_back(n);
    end
    @(negedge sys_clk);
    n++;
    if (ramp) begin
      ad_data_ch0 = 12'(n);
      ad_data_ch1 = 12'h800 + 12'(n);
    end
    #1;
    if (done) begin
      done_cnt++;
      done_n = n;
      busy_at_done = busy;
    end
  endtask
  task automatic clear();
    bd.delete();
    bl.delete();
    bn.delete();
    n = 0;
    done_cnt = 0;
    done_n = -1;
    ad_data_ch0 = 12'h000;
    ad_data_ch1 = 12'h800;
  endtask
  task automatic start(input int len, input int dec, input int mode);
    cfg_len = 16'(len);
    cfg_decim = 8'(dec);
    cfg_trig_mode = 2'(mode);
    cfg_start = 1'b1;
    cycle();
    cfg_start = 1'b0;
    cfg_len = 16'd1;
    cfg_decim = 8'd7;
    cfg_trig_mode = 2'd2;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    #1;
    checks++;
    if ({m_valid, m_last, busy, done, overflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 00000", {m_valid, m_last, busy, done, overflow});
    end
    checks++;
    if (m_data !== 24'h0 || sample_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_data got data %h cnt %0d exp 0 0", m_data, sample_cnt);
    end
    rst_n = 1'b1;
    @(negedge sys_clk);
    #1;
  endtask
  task automatic test_mode0();
    clear();
    ramp = 1'b1;
    m_ready = 1'b1;
    start(4, 0, 0);
    repeat (10) cycle();
    checks++;
    if (bd.size() !== 4) begin
      errors++;
      $display("FAIL mode0_beats got %0d exp 4", bd.size());
    end
    for (int i = 0; i < 4 && i < bd.size(); i++) begin
      checks++;
      if (bd[i] !== beat(1 + i) || bl[i] !== (i == 3) || bn[i] !== 3 + i) begin
        errors++;
        $display("FAIL mode0_beat%0d got %h last %b cyc %0d exp %h last %b cyc %0d",
                 i, bd[i], bl[i], bn[i], beat(1 + i), i == 3, 3 + i);
      end
    end
    checks++;
    if (done_cnt !== 1 || done_n !== 7 || busy_at_done !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL mode0_done got cnt %0d cyc %0d busy %b ovf %b exp 1 7 0 0",
               done_cnt, done_n, busy_at_done, overflow);
    end
  endtask
  task automatic test_decim();
    clear();
    ramp = 1'b1;
    m_ready = 1'b1;
    start(3, 2, 0);
    repeat (15) cycle();
    checks++;
    if (bd.size() !== 3 || done_cnt !== 1) begin
      errors++;
      $display("FAIL decim_count got beats %0d done %0d exp 3 1", bd.size(), done_cnt);
    end
    for (int i = 0; i < 3 && i < bd.size(); i++) begin
      checks++;
      if (bd[i] !== beat(1 + 3 * i) || bl[i] !== (i == 2)) begin
        errors++;
        $display("FAIL decim_beat%0d got %h last %b exp %h last %b", i, bd[i], bl[i], beat(1 + 3 * i), i == 2);
      end
    end
  endtask
  task automatic test_thresh();
    clear();
    ramp = 1'b0;
    m_ready = 1'b1;
    ad_data_ch0 = 12'h100;
    ad_data_ch1 = 12'h0AA;
    repeat (2) cycle();
    n = 0;
    cfg_thresh = 12'h400;
    ad_data_ch0 = 12'h500;
    start(2, 0, 1);
    cfg_thresh = 12'hFFF;
    while (n < 16) begin
      ad_data_ch0 = (n < 4) ? 12'h500 : (n < 7) ? 12'h100 : 12'(12'h400 + n - 7);
      cycle();
    end
    checks++;
    if (bd.size() !== 2 || done_cnt !== 1) begin
      errors++;
      $display("FAIL thresh_count got beats %0d done %0d exp 2 1", bd.size(), done_cnt);
    end
    if (bd.size() == 2) begin
      checks++;
      if (bd[0] !== 24'h0AA401 || bn[0] !== 10 || bd[1] !== 24'h0AA402 || bl[1] !== 1'b1) begin
        errors++;
        $display("FAIL thresh_beats got %h@%0d %h last %b exp 0aa401@10 0aa402 last 1",
                 bd[0], bn[0], bd[1], bl[1]);
      end
    end
  endtask
  task automatic test_ext();
    clear();
    ramp = 1'b1;
    m_ready = 1'b1;
    ext_trig = 1'b0;
    start(1, 0, 2);
    while (n < 12) begin
      ext_trig = (n == 4);
      cycle();
    end
    checks++;
    if (bd.size() !== 1 || bd[0] !== beat(4) || bn[0] !== 6 || bl[0] !== 1'b1) begin
      errors++;
      $display("FAIL ext_beat got n %0d data %h cyc %0d exp 1 %h 6", bd.size(), bd[0], bn[0], beat(4));
    end
  endtask
  task automatic test_overflow();
    clear();
    ramp = 1'b1;
    m_ready = 1'b0;
    start(16, 0, 0);
    while (n < 20) cycle();
    checks++;
    if (sample_cnt !== 16'd8 || overflow !== 1'b1 || m_valid !== 1'b1 || m_data !== beat(1)) begin
      errors++;
      $display("FAIL ovf_stall got cnt %0d ovf %b valid %b data %h exp 8 1 1 %h",
               sample_cnt, overflow, m_valid, m_data, beat(1));
    end
    m_ready = 1'b1;
    while (n < 45) cycle();
    checks++;
    if (bd.size() !== 16 || done_cnt !== 1 || done_n !== 36 || sample_cnt !== 16'd16 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_summary got beats %0d done %0d@%0d cnt %0d ovf %b exp 16 1@36 16 1",
               bd.size(), done_cnt, done_n, sample_cnt, overflow);
    end
    for (int i = 0; i < 16 && i < bd.size(); i++) begin
      checks++;
      if (bd[i] !== beat(i < 8 ? i + 1 : i + 11) || bl[i] !== (i == 15) || bn[i] !== 20 + i) begin
        errors++;
        $display("FAIL ovf_beat%0d got %h last %b cyc %0d exp %h last %b cyc %0d",
                 i, bd[i], bl[i], bn[i], beat(i < 8 ? i + 1 : i + 11), i == 15, 20 + i);
      end
    end
  endtask
  task automatic test_abort();
    clear();
    ramp = 1'b1;
    m_ready = 1'b0;
    start(10, 0, 0);
    checks++;
    if (overflow !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_start got ovf %b busy %b exp 0 1", overflow, busy);
    end
    while (n < 5) cycle();
    checks++;
    if (sample_cnt !== 16'd3 || m_valid !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre got cnt %0d valid %b exp 3 1", sample_cnt, m_valid);
    end
    cfg_abort = 1'b1;
    cycle();
    cfg_abort = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || sample_cnt !== 16'd3) begin
      errors++;
      $display("FAIL abort_post got valid %b busy %b cnt %0d exp 0 0 3", m_valid, busy, sample_cnt);
    end
    repeat (5) cycle();
    checks++;
    if (done_cnt !== 0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_nodone got done %0d valid %b exp 0 0", done_cnt, m_valid);
    end
    clear();
    m_ready = 1'b1;
    start(2, 0, 0);
    repeat (10) cycle();
    checks++;
    if (bd.size() !== 2 || bd[0] !== beat(1) || bd[1] !== beat(2) || bl[1] !== 1'b1 || done_cnt !== 1) begin
      errors++;
      $display("FAIL abort_restart got beats %0d %h %h done %0d exp 2 %h %h 1",
               bd.size(), bd[0], bd[1], done_cnt, beat(1), beat(2));
    end
  endtask
  task automatic test_ignore();
    clear();
    ramp = 1'b1;
    m_ready = 1'b1;
    start(0, 0, 0);
    repeat (4) cycle();
    checks++;
    if (busy !== 1'b0 || done_cnt !== 0 || sample_cnt !== 16'd2 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL ign_len0 got busy %b done %0d cnt %0d valid %b exp 0 0 2 0",
               busy, done_cnt, sample_cnt, m_valid);
    end
    cfg_abort = 1'b1;
    start(3, 0, 0);
    cfg_abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || sample_cnt !== 16'd2) begin
      errors++;
      $display("FAIL ign_abort_start got busy %b cnt %0d exp 0 2", busy, sample_cnt);
    end
    clear();
    m_ready = 1'b0;
    start(3, 0, 0);
    while (n < 10) begin
      cfg_len = 16'd1;
      cfg_start = (n == 2 || n == 6);
      m_ready = (n >= 6);
      cycle();
    end
    cfg_start = 1'b0;
    checks++;
    if (bd.size() !== 3 || bn[0] !== 6 || bd[2] !== beat(3) || bl[2] !== 1'b1 || done_cnt !== 1 || done_n !== 9 || sample_cnt !== 16'd3) begin
      errors++;
      $display("FAIL ign_busy got beats %0d cyc0 %0d done %0d@%0d cnt %0d exp 3 6 1@9 3",
               bd.size(), bn[0], done_cnt, done_n, sample_cnt);
    end
  endtask
  initial begin
    test_reset();
    test_mode0();
    test_decim();
    test_thresh();
    test_ext();
    test_overflow();
    test_abort();
    test_ignore();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
